// File: rtl/slc_pkg.sv
// Shared types and helpers for the parametrised SLC datapath.
//   pcmux_t  - PC next-value source select
//   addr2_t  - ADDR2 offset select for the address adder
//   aluk_t   - ALU operation select
//   R7_IDX   - link register index used when DRMUX selects R7
//   sext()   - sign-extend the low src_w bits of a value to SextMaxW bits
package slc_pkg;

  // Widest datapath the sext helper supports; callers cast the result to W.
  localparam int unsigned SextMaxW = 64;

  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDR, PC_HOLD} pcmux_t;
  typedef enum logic [1:0] {ADDR2_ZERO, ADDR2_OFF6, ADDR2_OFF9, ADDR2_OFF11} addr2_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_t;

  localparam logic [2:0] R7_IDX = 3'd7;

  function automatic logic [SextMaxW-1:0] sext(input logic [SextMaxW-1:0] val,
                                               input int unsigned src_w);
    logic [SextMaxW-1:0] ext_mask;
    logic [5:0]          sign_idx;
    ext_mask = {SextMaxW{1'b1}} << src_w;
    sign_idx = 6'(src_w - 1);
    return val[sign_idx] ? (val | ext_mask) : (val & ~ext_mask);
  endfunction

endpackage

// File: rtl/slc_datapath_p_reg_file.sv
// 8 x W general register file: one synchronous write port, two combinational
// read ports. A read of the register being written returns the old value.
//   clk_i, rst_ni      - clock, async active-low reset (all registers to 0)
//   we_i/waddr_i/wdata_i - write port
//   raddr1_i/rdata1_o  - read port 1 (SR1)
//   raddr2_i/rdata2_o  - read port 2 (SR2)
module slc_reg_file #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [2:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic [2:0]   raddr1_i,
  output logic [W-1:0] rdata1_o,
  input  logic [2:0]   raddr2_i,
  output logic [W-1:0] rdata2_o
);

  logic [W-1:0] regs_q [8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/slc_datapath_p.sv
// Parametrised SLC datapath: PC, MAR, MDR, IR, register file, ALU, address
// adder, NZP/BEN and LED latch around one shared bus, plus gate-conflict
// detection and a memory-ready stall/timeout monitor.
//   clk_i, rst_ni               - clock, async active-low reset
//   ld_*_i                      - register load enables from control
//   gate_*_i                    - bus drivers (one-hot expected)
//   *mux_i, aluk_i              - mux / operation selects
//   mio_en_i, mdr_in_i, mem_rdy_i - memory read path and handshake
//   mar_o, mdr_o, ir_o, pc_o    - architectural registers
//   ben_o, nzp_o, led_o         - branch enable, condition codes, LED latch
//   stall_o                     - memory read pending (combinational)
//   bus_err_o, err_cnt_o        - sticky conflict flag, saturating count
//   mem_timeout_o               - sticky memory timeout flag
module slc_datapath_p
  import slc_pkg::*;
#(
  parameter int unsigned   W           = 16,
  parameter logic [W-1:0]  PC_RESET    = '0,
  parameter int unsigned   LED_W       = 12,
  parameter int unsigned   ERR_CNT_W   = 8,
  parameter int unsigned   MEM_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ld_mar_i,
  input  logic                 ld_mdr_i,
  input  logic                 ld_ir_i,
  input  logic                 ld_ben_i,
  input  logic                 ld_cc_i,
  input  logic                 ld_reg_i,
  input  logic                 ld_pc_i,
  input  logic                 ld_led_i,
  input  logic                 gate_pc_i,
  input  logic                 gate_mdr_i,
  input  logic                 gate_alu_i,
  input  logic                 gate_marmux_i,
  input  logic                 sr2mux_i,
  input  logic                 addr1mux_i,
  input  logic                 marmux_i,
  input  logic                 drmux_i,
  input  logic                 sr1mux_i,
  input  logic [1:0]           pcmux_i,
  input  logic [1:0]           addr2mux_i,
  input  logic [1:0]           aluk_i,
  input  logic                 mio_en_i,
  input  logic [W-1:0]         mdr_in_i,
  input  logic                 mem_rdy_i,
  output logic [W-1:0]         mar_o,
  output logic [W-1:0]         mdr_o,
  output logic [W-1:0]         ir_o,
  output logic [W-1:0]         pc_o,
  output logic                 ben_o,
  output logic [2:0]           nzp_o,
  output logic [LED_W-1:0]     led_o,
  output logic                 stall_o,
  output logic                 bus_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 mem_timeout_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic [2:0] nzp_q, nzp_d;
  logic ben_q, ben_d, bus_err_q, bus_err_d, timeout_q, timeout_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

  logic [W-1:0] bus, sr1, sr2, alu_b, alu_out, addr1, addr2, addr_sum, marmux_out;
  logic [W-1:0] off5, off6, off9, off11;
  logic [3:0] gates;
  logic gate_conflict, stall;
  pcmux_t pcmux;
  addr2_t addr2_sel;
  aluk_t aluk;

  assign pcmux     = pcmux_t'(pcmux_i);
  assign addr2_sel = addr2_t'(addr2mux_i);
  assign aluk      = aluk_t'(aluk_i);

  assign off5  = W'(sext(SextMaxW'(ir_q[4:0]), 5));
  assign off6  = W'(sext(SextMaxW'(ir_q[5:0]), 6));
  assign off9  = W'(sext(SextMaxW'(ir_q[8:0]), 9));
  assign off11 = W'(sext(SextMaxW'(ir_q[10:0]), 11));

  slc_reg_file #(.W(W)) u_reg_file (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we_i     (ld_reg_i),
    .waddr_i  (drmux_i ? R7_IDX : ir_q[11:9]),
    .wdata_i  (bus),
    .raddr1_i (sr1mux_i ? ir_q[8:6] : ir_q[11:9]),
    .rdata1_o (sr1),
    .raddr2_i (ir_q[2:0]),
    .rdata2_o (sr2)
  );

  // ALU and address adder
  assign alu_b = sr2mux_i ? off5 : sr2;
  always_comb begin
    alu_out = '0;
    unique case (aluk)
      ALU_ADD:  alu_out = sr1 + alu_b;
      ALU_AND:  alu_out = sr1 & alu_b;
      ALU_NOT:  alu_out = ~sr1;
      ALU_PASS: alu_out = sr1;
      default:  alu_out = '0;
    endcase
  end

  assign addr1 = addr1mux_i ? sr1 : pc_q;
  always_comb begin
    addr2 = '0;
    unique case (addr2_sel)
      ADDR2_ZERO:  addr2 = '0;
      ADDR2_OFF6:  addr2 = off6;
      ADDR2_OFF9:  addr2 = off9;
      ADDR2_OFF11: addr2 = off11;
      default:     addr2 = '0;
    endcase
  end
  assign addr_sum   = addr1 + addr2;
  assign marmux_out = marmux_i ? addr_sum : W'(ir_q[7:0]);

  // Shared bus: any multi-driver combination collapses to all ones.
  assign gates         = {gate_pc_i, gate_mdr_i, gate_alu_i, gate_marmux_i};
  assign gate_conflict = |(gates & (gates - 4'd1));
  always_comb begin
    bus = '0;
    case (gates)
      4'b0000: bus = '0;
      4'b1000: bus = pc_q;
      4'b0100: bus = mdr_q;
      4'b0010: bus = alu_out;
      4'b0001: bus = marmux_out;
      default: bus = '1;
    endcase
  end

  assign stall = ld_mdr_i & mio_en_i & ~mem_rdy_i;

  always_comb begin
    pc_d        = pc_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    ir_d        = ir_q;
    nzp_d       = nzp_q;
    ben_d       = ben_q;
    led_d       = led_q;
    bus_err_d   = bus_err_q | gate_conflict;
    err_cnt_d   = err_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = '0;

    if (ld_pc_i) begin
      unique case (pcmux)
        PC_INC:  pc_d = pc_q + W'(1);
        PC_BUS:  pc_d = bus;
        PC_ADDR: pc_d = addr_sum;
        PC_HOLD: pc_d = pc_q;
        default: pc_d = pc_q;
      endcase
    end
    if (ld_mar_i) mar_d = bus;
    if (ld_ir_i)  ir_d  = bus;
    if (ld_led_i) led_d = ir_q[LED_W-1:0];
    if (ld_mdr_i) begin
      if (!mio_en_i)      mdr_d = bus;
      else if (mem_rdy_i) mdr_d = mdr_in_i;
    end
    if (ld_cc_i) begin
      if (bus[W-1])       nzp_d = 3'b100;
      else if (bus == '0) nzp_d = 3'b010;
      else                nzp_d = 3'b001;
    end
    if (ld_ben_i) ben_d = |(ir_q[11:9] & nzp_q);
    if (gate_conflict && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);

    // Flag sets on the edge where the count reaches the limit; count then holds.
    if (stall) begin
      if (stall_cnt_q == CntW'(MEM_TIMEOUT)) begin
        stall_cnt_d = stall_cnt_q;
      end else begin
        stall_cnt_d = stall_cnt_q + CntW'(1);
      end
      if (stall_cnt_d == CntW'(MEM_TIMEOUT)) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= PC_RESET;
      mar_q       <= '0;
      mdr_q       <= '0;
      ir_q        <= '0;
      nzp_q       <= '0;
      ben_q       <= 1'b0;
      led_q       <= '0;
      bus_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      ir_q        <= ir_d;
      nzp_q       <= nzp_d;
      ben_q       <= ben_d;
      led_q       <= led_d;
      bus_err_q   <= bus_err_d;
      err_cnt_q   <= err_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign mar_o         = mar_q;
  assign mdr_o         = mdr_q;
  assign ir_o          = ir_q;
  assign nzp_o         = nzp_q;
  assign ben_o         = ben_q;
  assign led_o         = led_q;
  assign stall_o       = stall;
  assign bus_err_o     = bus_err_q;
  assign err_cnt_o     = err_cnt_q;
  assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_slc_datapath_p.sv
// Directed bench for slc_datapath_p (W=16, PC_RESET=16'h3000).
// Expected values are pushed to a scoreboard queue as stimulus is driven and
// popped when the corresponding DUT output is sampled.
module tb_slc_datapath_p;

  localparam int unsigned W = 16;

  logic clk = 1'b0, rst_n;
  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic gate_pc, gate_mdr, gate_alu, gate_marmux;
  logic sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en, mem_rdy;
  logic [1:0] pcmux, addr2mux, aluk;
  logic [W-1:0] mdr_in;
  logic [W-1:0] mar, mdr, ir, pc;
  logic ben, stall, bus_err, mem_timeout;
  logic [2:0] nzp;
  logic [11:0] led;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  slc_datapath_p #(.W(W), .PC_RESET(16'h3000)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ld_mar_i(ld_mar), .ld_mdr_i(ld_mdr), .ld_ir_i(ld_ir), .ld_ben_i(ld_ben),
    .ld_cc_i(ld_cc), .ld_reg_i(ld_reg), .ld_pc_i(ld_pc), .ld_led_i(ld_led),
    .gate_pc_i(gate_pc), .gate_mdr_i(gate_mdr), .gate_alu_i(gate_alu),
    .gate_marmux_i(gate_marmux),
    .sr2mux_i(sr2mux), .addr1mux_i(addr1mux), .marmux_i(marmux), .drmux_i(drmux),
    .sr1mux_i(sr1mux), .pcmux_i(pcmux), .addr2mux_i(addr2mux), .aluk_i(aluk),
    .mio_en_i(mio_en), .mdr_in_i(mdr_in), .mem_rdy_i(mem_rdy),
    .mar_o(mar), .mdr_o(mdr), .ir_o(ir), .pc_o(pc), .ben_o(ben), .nzp_o(nzp),
    .led_o(led), .stall_o(stall), .bus_err_o(bus_err), .err_cnt_o(err_cnt),
    .mem_timeout_o(mem_timeout)
  );

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      t = "empty_scoreboard";
      e = 32'hDEAD_BEEF;
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
    end
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic clr();
    {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led} = '0;
    {gate_pc, gate_mdr, gate_alu, gate_marmux} = '0;
    {sr2mux, addr1mux, marmux, drmux, sr1mux, mio_en} = '0;
    pcmux = 2'b11; addr2mux = '0; aluk = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MDR <- v through the memory path with ready already high.
  task automatic load_mdr(input logic [W-1:0] v);
    clr(); mio_en = 1; ld_mdr = 1; mem_rdy = 1; mdr_in = v;
    tick(); clr();
  endtask

  // IR <- v via MDR.
  task automatic load_ir(input logic [W-1:0] v);
    load_mdr(v);
    gate_mdr = 1; ld_ir = 1;
    tick(); clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr(); rst_n = 0; mem_rdy = 0; mdr_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1; #1;

    // Reset state
    push("rst_pc", 32'h3000);  chk(pc);
    push("rst_mar", 0);        chk(mar);
    push("rst_mdr", 0);        chk(mdr);
    push("rst_ir", 0);         chk(ir);
    push("rst_nzp", 0);        chk(nzp);
    push("rst_ben", 0);        chk(ben);
    push("rst_led", 0);        chk(led);
    push("rst_stall", 0);      chk(stall);
    push("rst_flags", 0);      chk({bus_err, mem_timeout, err_cnt});

    // Fetch: MAR <- PC, PC <- PC+1
    gate_pc = 1; ld_mar = 1; ld_pc = 1; pcmux = 2'b00;
    push("fetch_mar", 32'h3000); push("fetch_pc", 32'h3001);
    tick(); clr();
    chk(mar); chk(pc);

    // Memory read with three not-ready cycles
    mio_en = 1; ld_mdr = 1; mem_rdy = 0; mdr_in = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1; push("stall_hi", 1); chk(stall);
      tick();
    end
    push("mdr_hold", 0); chk(mdr);
    mem_rdy = 1; #1;
    push("stall_lo", 0); chk(stall);
    push("mdr_read", 32'hBEEF);
    tick(); clr();
    chk(mdr);

    // ADD R1,R1,#1 with R1 = 7FFF
    load_ir(16'h1261);
    push("ir_load", 32'h1261); chk(ir);
    load_mdr(16'h7FFF);
    gate_mdr = 1; ld_reg = 1;
    tick(); clr();
    gate_alu = 1; sr2mux = 1; sr1mux = 1; aluk = 2'b00; ld_reg = 1; ld_cc = 1;
    push("add_nzp", 32'b100);
    tick(); clr();
    chk(nzp);
    gate_alu = 1; sr1mux = 1; aluk = 2'b11; ld_mar = 1;
    push("add_r1", 32'h8000);
    tick(); clr();
    chk(mar);

    // BEN from IR[11:9]=100 with N set, then LED latch
    load_ir(16'h0800);
    ld_ben = 1; ld_led = 1;
    push("ben_n", 1); push("led", 32'h800);
    tick(); clr();
    chk(ben); chk(led);
    ld_cc = 1;  // empty bus -> Z
    push("nzp_zero", 32'b010);
    tick(); clr();
    chk(nzp);
    ld_ben = 1;
    push("ben_z", 0);
    tick(); clr();
    chk(ben);

    // Gate conflict: three cycles, then saturation
    gate_pc = 1; gate_mdr = 1; ld_mar = 1;
    repeat (3) tick();
    push("conf_mar", 32'hFFFF); chk(mar);
    push("conf_err", 1);        chk(bus_err);
    push("conf_cnt3", 3);       chk(err_cnt);
    repeat (300) tick();
    clr();
    push("conf_sat", 255);      chk(err_cnt);
    tick();
    push("err_sticky", 1);      chk(bus_err);

    // Memory timeout
    mio_en = 1; ld_mdr = 1; mem_rdy = 0; mdr_in = 16'h1234;
    repeat (14) tick();
    push("to_early", 0); chk(mem_timeout);
    tick();
    push("to_set", 1); chk(mem_timeout);
    mem_rdy = 1;
    tick();
    push("to_sticky", 1); chk(mem_timeout);
    push("to_mdr", 32'h1234); chk(mdr);

    // Asynchronous reset in the middle of a stall
    mem_rdy = 0;
    repeat (3) tick();
    #2; rst_n = 0; #1;
    push("arst_mdr", 0);     chk(mdr);
    push("arst_flags", 0);   chk({bus_err, mem_timeout, err_cnt});
    push("arst_pc", 32'h3000); chk(pc);
    @(negedge clk); rst_n = 1;
    // Stall counter must restart from zero: 14 stalls do not time out
    repeat (14) tick();
    push("arst_cnt", 0); chk(mem_timeout);
    clr(); mem_rdy = 1;

    // MAR and PC capture the same bus value in one cycle
    load_mdr(16'hABCD);
    gate_mdr = 1; ld_mar = 1; ld_pc = 1; pcmux = 2'b01;
    push("same_mar", 32'hABCD); push("same_pc", 32'hABCD);
    tick(); clr();
    chk(mar); chk(pc);

    // PC wrap and PC-relative branch with offset -1
    load_mdr(16'hFFFF);
    gate_mdr = 1; ld_pc = 1; pcmux = 2'b01;
    tick(); clr();
    ld_pc = 1; pcmux = 2'b00;
    push("pc_wrap", 0);
    tick(); clr();
    chk(pc);
    load_ir(16'h01FF);
    ld_pc = 1; pcmux = 2'b10; addr1mux = 0; addr2mux = 2'b10;
    push("pc_off9", 32'hFFFF);
    tick(); clr();
    chk(pc);
    ld_pc = 1; pcmux = 2'b11;
    push("pc_hold", 32'hFFFF);
    tick(); clr();
    chk(pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
